// File: rtl/joy_poll_sched.sv
// Round-robin joystick poll scheduler: shares one SPI reader between two
// players, latching each player's x/y sample once per poll period.
module joy_poll_sched #(
   parameter int POLL_DIV = 250000,
   parameter int TIMEOUT  = 4096,
   parameter int CENTER   = 512
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       rst,
   input  logic       en1,
   input  logic       en2,
   output logic       spi_start,
   output logic       spi_sel,
   input  logic       spi_done,
   input  logic [9:0] spi_x,
   input  logic [9:0] spi_y,
   output logic [9:0] joy1_x,
   output logic [9:0] joy1_y,
   output logic [9:0] joy2_x,
   output logic [9:0] joy2_y,
   output logic       tick1,
   output logic       tick2,
   output logic [1:0] to_err,
   output logic       overrun
);

   localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PW-1:0] PLAST = PW'(POLL_DIV - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [9:0]    CTR   = 10'(CENTER);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_LATCH, S_NEXT} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          sel_q, sel_d;
   logic [9:0]    j1x_q, j1x_d, j1y_q, j1y_d, j2x_q, j2x_d, j2y_q, j2y_d;
   logic [1:0]    to_err_q, to_err_d;
   logic          ovr_q, ovr_d;
   logic          poll_tick;

   assign poll_tick = (pcnt_q == PLAST);

   // Next-state and datapath updates; every target defaults to its hold value.
   always_comb begin
      state_d  = state_q;
      pcnt_d   = poll_tick ? '0 : pcnt_q + 1'b1;
      tcnt_d   = '0;
      sel_d    = sel_q;
      j1x_d    = j1x_q;
      j1y_d    = j1y_q;
      j2x_d    = j2x_q;
      j2y_d    = j2y_q;
      to_err_d = to_err_q;
      ovr_d    = ovr_q;
      // A tick that lands while a round is busy is dropped, but remembered.
      if (poll_tick && state_q != S_IDLE) ovr_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (poll_tick) begin
               if (en1) begin
                  sel_d   = 1'b0;
                  state_d = S_START;
               end else if (en2) begin
                  sel_d   = 1'b1;
                  state_d = S_START;
               end
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            tcnt_d = tcnt_q + 1'b1;
            // A done landing on the last timeout cycle still counts as good.
            if (spi_done) begin
               if (sel_q) begin
                  j2x_d = spi_x;
                  j2y_d = spi_y;
               end else begin
                  j1x_d = spi_x;
                  j1y_d = spi_y;
               end
               state_d = S_LATCH;
            end else if (tcnt_q == TLAST) begin
               if (sel_q) begin
                  j2x_d = CTR;
                  j2y_d = CTR;
               end else begin
                  j1x_d = CTR;
                  j1y_d = CTR;
               end
               to_err_d[sel_q] = 1'b1;
               state_d = S_NEXT;
            end
         end
         S_LATCH: state_d = S_NEXT;
         S_NEXT: begin
            if (!sel_q && en2) begin
               sel_d   = 1'b1;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; rst mirrors clr but at the clock edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= S_IDLE;
         pcnt_q   <= '0;
         tcnt_q   <= '0;
         sel_q    <= 1'b0;
         j1x_q    <= CTR;
         j1y_q    <= CTR;
         j2x_q    <= CTR;
         j2y_q    <= CTR;
         to_err_q <= 2'b00;
         ovr_q    <= 1'b0;
      end else if (rst) begin
         state_q  <= S_IDLE;
         pcnt_q   <= '0;
         tcnt_q   <= '0;
         sel_q    <= 1'b0;
         j1x_q    <= CTR;
         j1y_q    <= CTR;
         j2x_q    <= CTR;
         j2y_q    <= CTR;
         to_err_q <= 2'b00;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         tcnt_q   <= tcnt_d;
         sel_q    <= sel_d;
         j1x_q    <= j1x_d;
         j1y_q    <= j1y_d;
         j2x_q    <= j2x_d;
         j2y_q    <= j2y_d;
         to_err_q <= to_err_d;
         ovr_q    <= ovr_d;
      end
   end

   assign spi_start = (state_q == S_START);
   assign spi_sel   = sel_q;
   assign tick1     = (state_q == S_LATCH) && !sel_q;
   assign tick2     = (state_q == S_LATCH) && sel_q;
   assign joy1_x    = j1x_q;
   assign joy1_y    = j1y_q;
   assign joy2_x    = j2x_q;
   assign joy2_y    = j2y_q;
   assign to_err    = to_err_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_joy_poll_sched.sv
// Directed bench for joy_poll_sched with a short poll period and timeout.
module tb_joy_poll_sched;

   logic       clk = 1'b0;
   logic       clr, rst, en1, en2, spi_done;
   logic [9:0] spi_x, spi_y;
   logic       spi_start, spi_sel, tick1, tick2, overrun;
   logic [9:0] joy1_x, joy1_y, joy2_x, joy2_y;
   logic [1:0] to_err;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   localparam logic [39:0] ALL_CTR = {4{10'd512}};

   joy_poll_sched #(.POLL_DIV(32), .TIMEOUT(16), .CENTER(512)) dut (
      .clk(clk), .clr(clr), .rst(rst), .en1(en1), .en2(en2),
      .spi_start(spi_start), .spi_sel(spi_sel), .spi_done(spi_done),
      .spi_x(spi_x), .spi_y(spi_y),
      .joy1_x(joy1_x), .joy1_y(joy1_y), .joy2_x(joy2_x), .joy2_y(joy2_y),
      .tick1(tick1), .tick2(tick2), .to_err(to_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance negedges until spi_start is seen or the budget runs out.
   task automatic wait_start(input int lim, output int n);
      n = 0;
      while (!spi_start && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Called in the START cycle; returns in the LATCH cycle.
   task automatic respond(input logic [9:0] x, input logic [9:0] y);
      @(negedge clk);
      @(negedge clk);
      spi_done = 1'b1;
      spi_x    = x;
      spi_y    = y;
      @(negedge clk);
      spi_done = 1'b0;
   endtask

   task automatic watch(input int n, output int s1, output int s2, output int t1, output int t2);
      s1 = 0; s2 = 0; t1 = 0; t2 = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (spi_start && !spi_sel) s1++;
         if (spi_start && spi_sel)  s2++;
         if (tick1) t1++;
         if (tick2) t2++;
      end
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n, c0, m, s1, s2, t1, t2;
      clr = 1'b1; rst = 1'b0; en1 = 1'b1; en2 = 1'b1;
      spi_done = 1'b0; spi_x = '0; spi_y = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_start", spi_start, 0);
      chk("rst_sel", spi_sel, 0);
      chk("rst_joy", {joy1_x, joy1_y, joy2_x, joy2_y}, ALL_CTR);
      chk("rst_ticks", {tick1, tick2}, 0);
      chk("rst_flags", {to_err, overrun}, 0);
      clr = 1'b0;

      // Both players answer after a short delay
      wait_start(40, n);
      chk("t1_start_p1", spi_start, 1);
      chk("t1_sel_p1", spi_sel, 0);
      c0 = cyc;
      respond(10'd100, 10'd900);
      chk("t1_tick_p1", {tick1, tick2}, 2'b10);
      chk("t1_joy1", {joy1_x, joy1_y}, {10'd100, 10'd900});
      chk("t1_sel_latch", spi_sel, 0);
      @(negedge clk);
      chk("t1_tick1_once", tick1, 0);
      wait_start(5, n);
      chk("t1_p2_gap", n, 1);
      chk("t1_sel_p2", spi_sel, 1);
      respond(10'd700, 10'd300);
      chk("t1_tick_p2", {tick1, tick2}, 2'b01);
      chk("t1_joy2", {joy2_x, joy2_y}, {10'd700, 10'd300});
      chk("t1_joy1_hold", {joy1_x, joy1_y}, {10'd100, 10'd900});
      @(negedge clk);
      chk("t1_flags", {to_err, overrun}, 0);
      wait_start(40, n);
      chk("t1_period", cyc - c0, 32);
      chk("t1_sel_again", spi_sel, 0);
      respond(10'd101, 10'd901);
      chk("t1_joy1_upd", {joy1_x, joy1_y}, {10'd101, 10'd901});
      @(negedge clk);
      wait_start(5, n);
      respond(10'd701, 10'd301);
      chk("t1_joy2_upd", {joy2_x, joy2_y}, {10'd701, 10'd301});

      // Soft reset, then player 2 disabled
      en2 = 1'b0;
      pulse_rst();
      chk("t2_rst_joy", {joy1_x, joy1_y, joy2_x, joy2_y}, ALL_CTR);
      wait_start(40, n);
      chk("t2_sel_p1", spi_sel, 0);
      respond(10'd11, 10'd22);
      chk("t2_joy1", {joy1_x, joy1_y}, {10'd11, 10'd22});
      watch(25, s1, s2, t1, t2);
      chk("t2_no_p2_start", s2, 0);
      chk("t2_no_tick2", t2, 0);
      wait_start(40, n);
      chk("t2_sel_p1b", {spi_start, spi_sel}, 2'b10);
      respond(10'd33, 10'd44);
      watch(10, s1, s2, t1, t2);
      chk("t2_no_p2_start_b", s2, 0);
      chk("t2_joy2_ctr", {joy2_x, joy2_y}, {10'd512, 10'd512});

      // Player 1 never answers; player 2 still read
      en2 = 1'b1;
      wait_start(40, n);
      chk("t3_sel_p1", {spi_start, spi_sel}, 2'b10);
      m = 0; t1 = 0;
      do begin
         @(negedge clk);
         m++;
         if (tick1) t1++;
      end while (!spi_start && m < 40);
      chk("t3_wait_len", m, 18);
      chk("t3_sel_p2", spi_sel, 1);
      chk("t3_to_err", to_err, 2'b01);
      chk("t3_joy1_ctr", {joy1_x, joy1_y}, {10'd512, 10'd512});
      chk("t3_no_tick1", t1, 0);
      respond(10'd3, 10'd4);
      chk("t3_tick2", {tick1, tick2}, 2'b01);
      chk("t3_joy2", {joy2_x, joy2_y}, {10'd3, 10'd4});

      // spi_done on the final timeout cycle wins
      pulse_rst();
      chk("t4_to_err_clr", to_err, 0);
      wait_start(40, n);
      chk("t4_sel_p1", {spi_start, spi_sel}, 2'b10);
      repeat (16) @(negedge clk);
      spi_done = 1'b1; spi_x = 10'd5; spi_y = 10'd6;
      @(negedge clk);
      spi_done = 1'b0;
      chk("t4_tick1", tick1, 1);
      chk("t4_joy1_x", joy1_x, 10'd5);
      chk("t4_to_err", to_err, 2'b00);
      @(negedge clk);
      wait_start(5, n);
      chk("t4_sel_p2", {spi_start, spi_sel}, 2'b11);
      respond(10'd8, 10'd9);
      chk("t4_tick2", tick2, 1);
      @(negedge clk);
      chk("t4_flags", {to_err, overrun}, 0);

      // Both time out: round outlasts the period
      wait_start(40, n);
      chk("t5_sel_p1", {spi_start, spi_sel}, 2'b10);
      @(negedge clk);
      wait_start(30, n);
      chk("t5_sel_p2", {spi_start, spi_sel}, 2'b11);
      watch(20, s1, s2, t1, t2);
      chk("t5_no_extra_start", s1 + s2, 0);
      chk("t5_overrun", overrun, 1);
      chk("t5_to_err", to_err, 2'b11);
      chk("t5_joy2_ctr", {joy2_x, joy2_y}, {10'd512, 10'd512});
      wait_start(40, n);
      chk("t5_next_round", {spi_start, spi_sel}, 2'b10);
      respond(10'd55, 10'd66);
      chk("t5_joy1", {tick1, joy1_x, joy1_y}, {1'b1, 10'd55, 10'd66});
      chk("t5_overrun_sticky", overrun, 1);

      // Soft reset during WAIT, then a stray done
      @(negedge clk);
      wait_start(5, n);
      chk("t6_sel_p2", {spi_start, spi_sel}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_start", spi_start, 0);
      chk("t6_joy", {joy1_x, joy1_y, joy2_x, joy2_y}, ALL_CTR);
      chk("t6_flags", {to_err, overrun}, 0);
      spi_done = 1'b1; spi_x = 10'd77; spi_y = 10'd88;
      @(negedge clk);
      spi_done = 1'b0;
      chk("t6_stray_ticks", {tick1, tick2}, 0);
      chk("t6_stray_joy", {joy1_x, joy1_y, joy2_x, joy2_y}, ALL_CTR);
      watch(10, s1, s2, t1, t2);
      chk("t6_quiet", s1 + s2 + t1 + t2, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/joy_poll_sched.md
# joy_poll_sched

Round-robin poll scheduler that shares one joystick SPI reader between two players. On every poll period it sequences one read per enabled joystick, latches each player's 10-bit x/y sample, and emits a one-cycle update strobe per player. It sits between the SPI master and the per-player cursor position updaters, which consume its joy_x/joy_y values and use its strobes as their cursor-update tick.

## Interface
- POLL_DIV, 250000: clk cycles per poll period; must be ≥ 4.
- TIMEOUT, 4096: max clk cycles spent in WAIT for spi_done; must be ≥ 2.
- CENTER, 512: neutral joystick value, used at reset and after a timeout.
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-high reset.
- rst  in  1  synchronous, active-high soft reset; same effect as clr, applied at the clock edge.
- en1, en2  in  1 each  player enable; a disabled player is skipped.
- spi_start  out  1  one-cycle request pulse to the SPI master.
- spi_sel  out  1  slave select: 0 = player 1, 1 = player 2.
- spi_done  in  1  one-cycle completion pulse from the SPI master.
- spi_x, spi_y  in  10 each  sample data; valid only in the cycle spi_done is high.
- joy1_x, joy1_y, joy2_x, joy2_y  out  10 each  latched samples.
- tick1, tick2  out  1 each  one-cycle pulse when that player's sample is updated from a good read.
- to_err  out  2  sticky timeout flags; bit 0 = player 1, bit 1 = player 2.
- overrun  out  1  sticky flag: a poll tick arrived while a round was still busy.

## Operation
- Reset values (clr or rst): state IDLE; poll counter 0; spi_start 0; spi_sel 0; all joy outputs = CENTER; tick1/tick2 0; to_err 0; overrun 0.
- Poll counter: free-running, counts 0..POLL_DIV-1 and wraps to 0. A poll tick is generated in the cycle the count equals POLL_DIV-1.
- States:
  - IDLE: on a poll tick, pick the first enabled player in the order P1 then P2 and go to START. If neither player is enabled, stay in IDLE.
  - START: drive spi_start = 1 with spi_sel = current player, then go to WAIT.
  - WAIT: the timeout counter is cleared on entry.
    - spi_done = 1: capture spi_x/spi_y into the current player's joy registers and go to LATCH.
    - Timeout counter reaches TIMEOUT-1 with no spi_done: set the player's joy registers to CENTER, set its to_err bit, and go to NEXT.
    - If spi_done and the timeout occur in the same cycle, spi_done wins.
  - LATCH: drive the current player's tick high for this one cycle, then go to NEXT.
  - NEXT: if the current player is P1 and en2 = 1, select P2 and go to START. Otherwise go to IDLE.
- Enables are sampled only when a player is selected, i.e. in IDLE and NEXT. Deasserting an enable mid-read does not abort that read.
- A poll tick seen outside IDLE is dropped and sets overrun. The poll counter keeps running.
- spi_done outside WAIT is ignored.
- to_err and overrun clear only on clr or rst.

## Timing
- spi_start is high for exactly one cycle, namely the cycle after the poll tick (or the cycle after NEXT for P2).
- spi_sel is stable from START through LATCH/NEXT of that read.
- spi_done sampled high at edge N: joy registers hold the new values from cycle N+1, and tick is high in cycle N+1 only.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then NEXT.
- Minimum round with both players enabled and immediate done: 8 cycles from poll tick to return to IDLE.
- Reset mid-operation: outputs return to reset values from the next cycle (clr: immediately). Any in-flight spi_done after reset is ignored.

## Test plan
- POLL_DIV=100, both enabled, spi_done 3 cycles after each spi_start with x=100, y=900 then x=700, y=300 -> joy1=(100,900) and tick1 pulses once, then joy2=(700,300) and tick2 pulses once, all within one period; repeats every 100 cycles.
- en2=0 -> only spi_sel=0 reads occur; joy2 stays 512/512; tick2 never pulses.
- TIMEOUT=16, P1 never answers -> WAIT lasts 16 cycles; joy1=512/512; to_err=01; P2 is still read normally; no tick1.
- spi_done arrives in the same cycle as the timeout, x=5 -> joy1_x=5; tick1 pulses; to_err stays 00.
- POLL_DIV=8, spi_done delayed 20 cycles -> overrun=1; the round completes correctly; no second spi_start while busy.
- rst asserted during WAIT, then a stray spi_done -> state IDLE; joy all 512; spi_start 0; no tick pulses.
